// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge: FSM state encoding,
// default bus widths and the word-alignment pattern for command addresses.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_WIDTH = 16;
    localparam int APB_DATA_WIDTH = 32;

    // Low address bits required for a legal word access.
    localparam logic [1:0] APB_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response channel plus APB3 bus seen by the bridge; the master
// modport is the bridge view, the slave modport is the surrounding system view.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 master, one transfer outstanding; optional ACCESS timeout under APB_TIMEOUT_EN.
// Latency: SETUP 1 cycle, ACCESS until PREADY, response held until rsp_ready; cmd_ready low while busy.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);

    apb_state_e state;

`ifdef APB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= DATA_WIDTH'(0);
            bus.rsp_err   <= 1'b0;
            bus.PADDR     <= ADDR_WIDTH'(0);
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= DATA_WIDTH'(0);
`ifdef APB_TIMEOUT_EN
            tcnt          <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        // Misaligned commands are answered locally and never reach the bus.
                        if (bus.cmd_addr[1:0] != APB_ALIGN_MASK) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= DATA_WIDTH'(0);
                            state         <= RESP;
                        end else begin
                            bus.PADDR  <= bus.cmd_addr;
                            bus.PWRITE <= bus.cmd_write;
                            bus.PWDATA <= bus.cmd_wdata;
                            bus.PSEL   <= 1'b1;
                            state      <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tcnt        <= '0;
`endif
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.PSLVERR;
                        bus.rsp_rdata <= (!bus.PWRITE && !bus.PSLVERR) ? bus.PRDATA : DATA_WIDTH'(0);
                        state         <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    // This cycle is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
                    else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= DATA_WIDTH'(0);
                        tcnt          <= '0;
                        state         <= RESP;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= DATA_WIDTH'(0);
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command/response interface into APB3 transfers.
- Sits directly upstream of the team's memory-mapped APB slave and drives its PADDR/PSEL/PENABLE/PWRITE/PWDATA.
- Collects PRDATA/PSLVERR and returns them on a held response channel.
- Exactly one outstanding transfer; no pipelining across APB transfers.

Parameters:
- ADDR_WIDTH, 16, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles allowed before abort. Used only with APB_TIMEOUT_EN; must be ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, misalignment or timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset values, applied at the first rising edge with rst=1:
  - All outputs 0 except cmd_ready=1.
  - State IDLE.
  - Timeout counter 0.
- Reset asserted mid-transfer abandons it; no response is issued.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register addr/write/wdata.
  - If cmd_addr[1:0]!=0: go to RESP with rsp_err=1, rsp_rdata=0, no bus activity.
  - Otherwise go to SETUP.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - PREADY is sampled only in ACCESS; its value in any other state is ignored.
  - On PREADY=1: capture rsp_err=PSLVERR. If read and !PSLVERR, rsp_rdata=PRDATA; otherwise rsp_rdata=0. Go to RESP.
  - PSEL/PENABLE deassert on the same edge the transfer completes.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable.
  - cmd_ready=0.
  - On rsp_ready go to IDLE.
  - A response accepted in cycle N allows a new command in cycle N+1.
- cmd_ready is 0 in SETUP, ACCESS and RESP.
- Latency with a slave that asserts registered PREADY one cycle after seeing PSEL&&PENABLE:
  - Command accepted at edge 0.
  - SETUP in cycle 1, ACCESS in cycles 2–3.
  - rsp_valid first high in cycle 4.
- Back-to-back transfers always pass through IDLE, so PSEL is low for at least 2 cycles between transfers.
- Simultaneous rsp_ready and a new cmd_valid in RESP: the response retires; the command waits for IDLE.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, drop PSEL/PENABLE and go to RESP with rsp_err=1, rsp_rdata=0.
  - PREADY=1 on the terminal cycle takes priority over the timeout.
- Undefined: no counter exists; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_pkg holds:
  - State enum (IDLE/SETUP/ACCESS/RESP).
  - APB_ADDR_WIDTH=16 and APB_DATA_WIDTH=32 default constants.
  - Alignment mask constant (2'b00).
- No sub-module; FSM, capture registers and timeout counter are inline.

Test Plan:
- Write 0xDEADBEEF to 0x0010, then read 0x0010 → PSEL/PENABLE sequence SETUP→ACCESS; read rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle 4 after accept.
- Read with cmd_addr=0x0012 → no PSEL pulse; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Slave returns PSLVERR=1 with PREADY on read of 0x0400 → rsp_err=1, rsp_rdata=0.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready=0, PSEL=0 throughout.
- Assert rst during ACCESS → next cycle PSEL=PENABLE=0, cmd_ready=1, no rsp_valid.
- With APB_TIMEOUT_EN and PREADY tied 0 → after 16 ACCESS cycles PSEL drops and rsp_err=1. Without the macro, PSEL stays high for 100+ cycles.
